// File: rtl/id_ex_fwd_stage_if.sv
// ID/EX stage bus: decoded ID-side fields in, registered EX-side fields and bypass selects out.
interface id_ex_fwd_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_alu_src;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              flush;
  logic [DATA_W-1:0] wb_data;

  logic              stall_o;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic              ex_alu_src;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read, id_alu_src,
           id_rs_data, id_rt_data, id_imm, flush, wb_data,
    input  stall_o, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_alu_src, ex_dest,
           ex_reg_write, ex_mem_read, sel_a, sel_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read, id_alu_src,
           id_rs_data, id_rt_data, id_imm, flush, wb_data,
    output stall_o, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_alu_src, ex_dest,
           ex_reg_write, ex_mem_read, sel_a, sel_b
  );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with bypass-select generation and load-use stall detection.
// Optional macro FWD_WB_WRITETHRU_EN: capture WB data for sources matching the WB destination.
module id_ex_fwd_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_fwd_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_rs_data_q;
  logic [DATA_W-1:0] ex_rt_data_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic              ex_alu_src_q;
  logic [REG_AW-1:0] ex_dest_q;
  logic              ex_reg_write_q;
  logic              ex_mem_read_q;
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;

  logic [REG_AW-1:0] mem_dest_q;
  logic              mem_rw_q;
  logic [REG_AW-1:0] wb_dest_q;
  logic              wb_rw_q;

  logic [CNT_W-1:0]  stall_cnt_q;

  logic              stall;
  logic              bubble;
  logic [DATA_W-1:0] rs_cap;
  logic [DATA_W-1:0] rt_cap;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;

  always_comb begin
    stall = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_dest_q != '0) &
            ((ex_dest_q == bus.id_rs) | (ex_dest_q == bus.id_rt)) & ~bus.flush;
    bubble = bus.flush | stall;
  end

`ifdef FWD_WB_WRITETHRU_EN
  // Register file has no write-first read, so patch in the value being written this cycle.
  always_comb begin
    rs_cap = bus.id_rs_data;
    rt_cap = bus.id_rt_data;
    if (wb_rw_q && (wb_dest_q != '0) && (wb_dest_q == bus.id_rs)) rs_cap = bus.wb_data;
    if (wb_rw_q && (wb_dest_q != '0) && (wb_dest_q == bus.id_rt)) rt_cap = bus.wb_data;
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^bus.wb_data;

  always_comb begin
    rs_cap = bus.id_rs_data;
    rt_cap = bus.id_rt_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_alu_src_q   <= 1'b0;
      ex_dest_q      <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
    end else if (bubble) begin
      ex_valid_q     <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_alu_src_q   <= 1'b0;
      ex_dest_q      <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
    end else begin
      ex_valid_q     <= bus.id_valid;
      ex_rs_data_q   <= rs_cap;
      ex_rt_data_q   <= rt_cap;
      ex_imm_q       <= bus.id_imm;
      ex_alu_src_q   <= bus.id_alu_src;
      ex_dest_q      <= bus.id_dest;
      ex_reg_write_q <= bus.id_reg_write;
      ex_mem_read_q  <= bus.id_mem_read;
      ex_rs_q        <= bus.id_rs;
      ex_rt_q        <= bus.id_rt;
    end
  end

  // Later stages never hold, so the shadow pipeline shifts unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_dest_q  <= '0;
      mem_rw_q    <= 1'b0;
      wb_dest_q   <= '0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      mem_dest_q <= ex_dest_q;
      mem_rw_q   <= ex_reg_write_q & ex_valid_q;
      wb_dest_q  <= mem_dest_q;
      wb_rw_q    <= mem_rw_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic              valid,
                                         input logic [REG_AW-1:0] src,
                                         input logic              m_rw,
                                         input logic [REG_AW-1:0] m_dest,
                                         input logic              w_rw,
                                         input logic [REG_AW-1:0] w_dest);
    logic [1:0] sel;
    sel = 2'b00;
    if (valid) begin
      if (m_rw && (m_dest != '0) && (m_dest == src))      sel = 2'b10;
      else if (w_rw && (w_dest != '0) && (w_dest == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    sel_a = fwd_sel(ex_valid_q, ex_rs_q, mem_rw_q, mem_dest_q, wb_rw_q, wb_dest_q);
    sel_b = fwd_sel(ex_valid_q, ex_rt_q, mem_rw_q, mem_dest_q, wb_rw_q, wb_dest_q);
  end

  assign bus.stall_o      = stall;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_rs_data   = ex_rs_data_q;
  assign bus.ex_rt_data   = ex_rt_data_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_alu_src   = ex_alu_src_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.sel_a        = sel_a;
  assign bus.sel_b        = sel_b;
  assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Scoreboard bench for id_ex_fwd_stage: a reference model pushes expected EX state per edge.
module tb_id_ex_fwd_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_fwd_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_ex_fwd_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              rw;
    logic              mr;
    logic              alu;
    logic [DATA_W-1:0] rsd;
    logic [DATA_W-1:0] rtd;
    logic [DATA_W-1:0] imm;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic              m_valid, m_rw, m_mr, m_alu;
  logic [REG_AW-1:0] m_dest, m_rs, m_rt, m_mem_dest, m_wb_dest;
  logic              m_mem_rw, m_wb_rw;
  logic [DATA_W-1:0] m_rsd, m_rtd, m_imm;
  logic [CNT_W-1:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_alu = 0; m_dest = 0; m_rs = 0; m_rt = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0;
    m_mem_dest = 0; m_mem_rw = 0; m_wb_dest = 0; m_wb_rw = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  function automatic logic [1:0] m_sel(input logic [REG_AW-1:0] src);
    if (!m_valid) return 2'b00;
    if (m_mem_rw && m_mem_dest != 0 && m_mem_dest == src) return 2'b10;
    if (m_wb_rw && m_wb_dest != 0 && m_wb_dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input logic valid, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] dest, input logic rw, input logic mr,
                       input logic alu, input logic fl);
    bus.id_valid     = valid;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_dest      = dest;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_alu_src   = alu;
    bus.flush        = fl;
    bus.id_rs_data   = $urandom;
    bus.id_rt_data   = $urandom;
    bus.id_imm       = $urandom;
    bus.wb_data      = $urandom;
  endtask

  // Checks stall, advances model and DUT by one edge, then compares the popped expectation.
  task automatic cycle();
    logic              stall;
    logic [DATA_W-1:0] rsd, rtd;
    exp_t e, g;
    #1;
    stall = bus.id_valid & m_valid & m_mr & (m_dest != 0) &
            ((m_dest == bus.id_rs) | (m_dest == bus.id_rt)) & ~bus.flush;
    check("stall_o", bus.stall_o, stall);
    rsd = bus.id_rs_data;
    rtd = bus.id_rt_data;
`ifdef FWD_WB_WRITETHRU_EN
    if (m_wb_rw && m_wb_dest != 0 && m_wb_dest == bus.id_rs) rsd = bus.wb_data;
    if (m_wb_rw && m_wb_dest != 0 && m_wb_dest == bus.id_rt) rtd = bus.wb_data;
`endif
    m_wb_dest  = m_mem_dest;
    m_wb_rw    = m_mem_rw;
    m_mem_dest = m_dest;
    m_mem_rw   = m_rw & m_valid;
    if (stall && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (stall || bus.flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_alu = 0; m_dest = 0; m_rs = 0; m_rt = 0;
      m_rsd = 0; m_rtd = 0; m_imm = 0;
    end else begin
      m_valid = bus.id_valid; m_rw = bus.id_reg_write; m_mr = bus.id_mem_read;
      m_alu = bus.id_alu_src; m_dest = bus.id_dest; m_rs = bus.id_rs; m_rt = bus.id_rt;
      m_rsd = rsd; m_rtd = rtd; m_imm = bus.id_imm;
    end
    e.valid = m_valid; e.dest = m_dest; e.rw = m_rw; e.mr = m_mr; e.alu = m_alu;
    e.rsd = m_rsd; e.rtd = m_rtd; e.imm = m_imm;
    e.sel_a = m_sel(m_rs); e.sel_b = m_sel(m_rt); e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      g = exp_q.pop_front();
      check("ex_valid", bus.ex_valid, g.valid);
      check("ex_dest", bus.ex_dest, g.dest);
      check("ex_reg_write", bus.ex_reg_write, g.rw);
      check("ex_mem_read", bus.ex_mem_read, g.mr);
      check("ex_alu_src", bus.ex_alu_src, g.alu);
      check("ex_rs_data", bus.ex_rs_data, g.rsd);
      check("ex_rt_data", bus.ex_rt_data, g.rtd);
      check("ex_imm", bus.ex_imm, g.imm);
      check("sel_a", bus.sel_a, g.sel_a);
      check("sel_b", bus.sel_b, g.sel_b);
      check("stall_cnt", stall_cnt, g.cnt);
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    model_reset();
    drive(1, 1, 2, 3, 1, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_ex_dest", bus.ex_dest, 0);
    check("rst_ex_rs_data", bus.ex_rs_data, 0);
    check("rst_ex_reg_write", bus.ex_reg_write, 0);
    check("rst_sel_a", bus.sel_a, 0);
    check("rst_sel_b", bus.sel_b, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall_o", bus.stall_o, 0);
    rst = 1'b0;

    // EX/MEM forward: add $3,$1,$2 ; sub $4,$3,$5
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle();
    check("first_capture_valid", bus.ex_valid, 1);
    drive(1, 3, 5, 4, 1, 0, 0, 0); cycle();
    check("exmem_sel_a", bus.sel_a, 2'b10);
    check("exmem_sel_b", bus.sel_b, 2'b00);
    nop(3);

    // MEM/WB forward: add $3 ; nop ; or $6,$3,$3
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle();
    nop(1);
    drive(1, 3, 3, 6, 1, 0, 0, 0); cycle();
    check("memwb_sel_a", bus.sel_a, 2'b01);
    check("memwb_sel_b", bus.sel_b, 2'b01);
    nop(3);

    // Priority: add $3 ; add $3 ; or $6,$3,$0
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle();
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle();
    drive(1, 3, 0, 6, 1, 0, 0, 0); cycle();
    check("prio_sel_a", bus.sel_a, 2'b10);
    check("prio_sel_b", bus.sel_b, 2'b00);
    nop(3);

    // Load-use: lw $2,0($1) ; add $4,$2,$2
    drive(1, 1, 2, 2, 1, 1, 1, 0); cycle();
    drive(1, 2, 2, 4, 1, 0, 0, 0);
    #1 check("lu_stall_on", bus.stall_o, 1);
    cycle();
    check("lu_bubble", bus.ex_valid, 0);
    drive(1, 2, 2, 4, 1, 0, 0, 0);
    #1 check("lu_stall_off", bus.stall_o, 0);
    cycle();
    check("lu_sel_a", bus.sel_a, 2'b01);
    check("lu_stall_cnt", stall_cnt, 1);
    nop(3);

    // Flush beats stall
    drive(1, 1, 2, 2, 1, 1, 1, 0); cycle();
    drive(1, 2, 2, 4, 1, 0, 0, 1);
    #1 check("flush_stall_o", bus.stall_o, 0);
    cycle();
    check("flush_bubble", bus.ex_valid, 0);
    check("flush_stall_cnt", stall_cnt, 1);
    nop(3);

    // $0 is never forwarded
    drive(1, 1, 1, 0, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 5, 1, 0, 0, 0); cycle();
    check("zero_sel_a", bus.sel_a, 2'b00);
    check("zero_sel_b", bus.sel_b, 2'b00);

    // Random traffic, then async reset in mid-operation
    for (int i = 0; i < 30; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
      cycle();
    end
    drive(1, 1, 2, 3, 1, 0, 0, 0); cycle();
    #2 rst = 1'b1;
    #1;
    check("midrst_ex_valid", bus.ex_valid, 0);
    check("midrst_ex_dest", bus.ex_dest, 0);
    check("midrst_stall_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Saturation: lw $2,0($2) held in ID stalls every other cycle -> 20 stalls
    for (int i = 0; i < 40; i++) begin
      drive(1, 2, 0, 2, 1, 1, 1, 0);
      cycle();
    end
    check("sat_stall_cnt", stall_cnt, 15);
    nop(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with forwarding-select generation for the EX-stage operand bypass muxes and load-use hazard detection.
- Captures decoded operands and control each cycle.
- Tracks destination register and RegWrite of the two older in-flight instructions (EX/MEM, MEM/WB) in internal shadow registers.
- Drives the 2-bit `sel` codes consumed by the operand-A and operand-B bypass muxes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-number width.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_AW  source register A number.
- id_rt  input  REG_AW  source register B number.
- id_dest  input  REG_AW  destination register, already muxed rd/rt/31.
- id_reg_write  input  1  instruction writes the register file.
- id_mem_read  input  1  instruction is a load.
- id_alu_src  input  1  ALU operand B is the immediate.
- id_rs_data  input  DATA_W  register-file read data A.
- id_rt_data  input  DATA_W  register-file read data B.
- id_imm  input  DATA_W  sign/zero-extended immediate.
- flush  input  1  squash the ID instruction (taken branch/jump).
- wb_data  input  DATA_W  write-back data (used only with the optional feature).
- stall_o  output  1  freeze PC and IF/ID this cycle.
- ex_valid  output  1  EX holds a real instruction.
- ex_rs_data  output  DATA_W  registered operand A.
- ex_rt_data  output  DATA_W  registered operand B.
- ex_imm  output  DATA_W  registered immediate.
- ex_alu_src  output  1  registered ALUSrc flag.
- ex_dest  output  REG_AW  registered destination.
- ex_reg_write  output  1  registered RegWrite.
- ex_mem_read  output  1  registered MemRead.
- sel_a  output  2  bypass select for operand A.
- sel_b  output  2  bypass select for operand B.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- **Reset (async, rst=1):**
  - All ex_* outputs are 0 (bubble).
  - Shadow registers mem_dest, mem_rw, wb_dest, wb_rw are 0.
  - stall_cnt is 0.
  - sel_a and sel_b are 2'b00; stall_o is 0.
  - Reset mid-operation discards all in-flight state immediately.
- **Load-use detection (combinational, same cycle):**
  - stall_o = id_valid & ex_valid & ex_mem_read & (ex_dest!=0) & ((ex_dest==id_rs) | (ex_dest==id_rt)) & ~flush.
- **ID/EX register update (every rising edge):**
  - If flush or stall_o: load a bubble (valid, reg_write, mem_read, alu_src, dest = 0; data fields = 0).
  - Else: capture all id_* fields.
  - The stage is never held; EX and later stages always advance.
  - flush has priority over stall: flush=1 forces stall_o=0 and loads a bubble.
- **Shadow pipeline (every edge, no hold):**
  - mem_dest <= ex_dest; mem_rw <= ex_reg_write & ex_valid.
  - wb_dest <= mem_dest; wb_rw <= mem_rw.
- **Forwarding selects (combinational from registered state), same encoding as the bypass mux:**
  - 2'b10 selects EX/MEM data; 2'b01 selects MEM/WB data; 2'b00 selects register data.
  - sel_a = 2'b10 if mem_rw & mem_dest!=0 & mem_dest==ex_rs; else 2'b01 if wb_rw & wb_dest!=0 & wb_dest==ex_rs; else 2'b00.
  - ex_rs is a registered copy of id_rs.
  - sel_b follows the same rule with ex_rt.
  - EX/MEM has priority when both stages match.
  - Register $0 is never forwarded.
  - sel_b is produced regardless of ex_alu_src; the mux gives ALUSrc precedence.
  - sel_* = 2'b11 is never driven.
  - sel_* = 2'b00 whenever ex_valid=0.
- **Latency:** one cycle from ID capture to ex_* outputs.
- **stall_cnt:** increments on each edge where stall_o=1; saturates at all-ones with no wrap.

Optional Feature:
- Macro: FWD_WB_WRITETHRU_EN.
- Defined:
  - At capture, if wb_rw & wb_dest!=0 & wb_dest==id_rs, ex_rs_data takes wb_data instead of id_rs_data.
  - ex_rt_data follows the same rule with id_rt.
  - This covers a register file without write-first read.
- Not defined:
  - wb_data is ignored.
  - id_*_data is captured unmodified.

Test Plan:
- Reset check: assert rst for 3 cycles with id_valid=1 -> all ex_* outputs = 0, sel_a = sel_b = 2'b00, stall_cnt = 0; release rst -> first capture on the next edge.
- EX/MEM forward: add $3,$1,$2 then sub $4,$3,$5 back-to-back -> while sub is in EX, sel_a = 2'b10 and sel_b = 2'b00.
- MEM/WB forward and priority:
  - add $3; nop; or $6,$3,$3 -> sel_a = sel_b = 2'b01.
  - add $3; add $3; or $6,$3,$0 -> sel_a = 2'b10.
- Load-use stall: lw $2,0($1) then add $4,$2,$2 -> stall_o = 1 for exactly 1 cycle, bubble in EX, then add in EX with sel_a = 2'b01; stall_cnt = 1.
- Flush priority: same lw/add pair with flush=1 in the stall cycle -> stall_o = 0, bubble loaded, stall_cnt unchanged.
- $0 and saturation:
  - add $0,$1,$1 followed by a consumer of $0 -> sel = 2'b00.
  - Force CNT_W = 4 and run 20 stalls -> stall_cnt = 15.
